// File: rtl/pomo_seq_ctrl.sv
// Pomodoro sequencer: work/break phase FSM with a one-second prescaler
// driving a BCD mm:ss countdown. All outputs are registered.
module pomo_seq_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int WORK_MIN  = 25,
  parameter int BREAK_MIN = 5,
  parameter int LONG_MIN  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_cancel,
  output logic [15:0] disp,
  output logic        running,
  output logic        paused,
  output logic        in_break,
  output logic [1:0]  session_cnt,
  output logic        phase_done
);

  typedef enum logic [2:0] {
    IDLE,
    RUN_WORK,
    RUN_BREAK,
    PAUSE_WORK,
    PAUSE_BREAK
  } state_t;

  localparam int PW = $clog2(TICK_DIV);

  // Minutes parameter to {tens, ones, 0, 0}; evaluated at elaboration only.
  function automatic logic [15:0] min_to_bcd(input int m);
    return {4'(m / 10), 4'(m % 10), 8'h00};
  endfunction

  localparam logic [15:0]   WORK_DISP  = min_to_bcd(WORK_MIN);
  localparam logic [15:0]   BREAK_DISP = min_to_bcd(BREAK_MIN);
  localparam logic [15:0]   LONG_DISP  = min_to_bcd(LONG_MIN);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);

  // {running, paused, in_break} for a given state.
  function automatic logic [2:0] flags_of(input state_t s);
    case (s)
      RUN_WORK:    return 3'b100;
      RUN_BREAK:   return 3'b101;
      PAUSE_WORK:  return 3'b010;
      PAUSE_BREAK: return 3'b011;
      default:     return 3'b000;
    endcase
  endfunction

  // One-second decrement of a non-zero mm:ss value with digit borrows.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    flags;

  assign {running, paused, in_break} = flags;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of state, disp and session_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flags       <= 3'b000;
      disp        <= WORK_DISP;
      presc       <= '0;
      session_cnt <= 2'd0;
      phase_done  <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (btn_cancel) begin
        state       <= IDLE;
        flags       <= flags_of(IDLE);
        disp        <= WORK_DISP;
        presc       <= '0;
        session_cnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (btn_start) begin
              state <= RUN_WORK;
              flags <= flags_of(RUN_WORK);
              disp  <= WORK_DISP;
              presc <= '0;
            end
          end
          RUN_WORK, RUN_BREAK: begin
            if (btn_pause) begin
              // A tick landing on this cycle is dropped; prescaler is frozen.
              state <= (state == RUN_WORK) ? PAUSE_WORK : PAUSE_BREAK;
              flags <= flags_of((state == RUN_WORK) ? PAUSE_WORK : PAUSE_BREAK);
            end else if (presc == PRESC_MAX) begin
              presc <= '0;
              if (disp != 16'h0000) begin
                disp <= bcd_dec(disp);
              end else if (state == RUN_WORK) begin
                state       <= RUN_BREAK;
                flags       <= flags_of(RUN_BREAK);
                session_cnt <= session_cnt + 2'd1;
                disp        <= (session_cnt == 2'd3) ? LONG_DISP : BREAK_DISP;
                phase_done  <= 1'b1;
              end else begin
                state      <= IDLE;
                flags      <= flags_of(IDLE);
                disp       <= WORK_DISP;
                phase_done <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE_WORK, PAUSE_BREAK: begin
            if (btn_pause || btn_start) begin
              state <= (state == PAUSE_WORK) ? RUN_WORK : RUN_BREAK;
              flags <= flags_of((state == PAUSE_WORK) ? RUN_WORK : RUN_BREAK);
            end
          end
          default: begin
            state <= IDLE;
            flags <= flags_of(IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pomo_seq_ctrl.sv
// Bench for pomo_seq_ctrl with TICK_DIV=4, WORK_MIN=1, BREAK_MIN=1, LONG_MIN=2.
// Phase-end outcomes are queued when a phase is started and checked on phase_done.
module tb_pomo_seq_ctrl;

  localparam int TD     = 4;
  localparam int PHASE1 = 61 * TD;   // start-to-expiry cycles of a 1-minute phase
  localparam int PHASE2 = 121 * TD;  // start-to-expiry cycles of a 2-minute phase

  logic        clk = 1'b0;
  logic        rst, btn_start, btn_pause, btn_cancel;
  logic [15:0] disp;
  logic        running, paused, in_break, phase_done;
  logic [1:0]  session_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] disp;
    logic [1:0]  sess;
    logic        brk;
    logic        run;
  } pd_exp_t;

  pd_exp_t    exp_q[$];
  logic [1:0] sess_model = 2'd0;

  pomo_seq_ctrl #(
    .TICK_DIV (TD),
    .WORK_MIN (1),
    .BREAK_MIN(1),
    .LONG_MIN (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_cancel (btn_cancel),
    .disp       (disp),
    .running    (running),
    .paused     (paused),
    .in_break   (in_break),
    .session_cnt(session_cnt),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every phase_done pulse must match the queued outcome.
  initial begin
    forever begin
      @(negedge clk);
      if (phase_done === 1'b1) begin
        pd_exp_t act, want;
        act = {disp, session_cnt, in_break, running};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: phase_done with no queued outcome, got %h", act);
        end else begin
          want = exp_q.pop_front();
          if (act !== want) begin
            n_bad++;
            $display("FAIL sb_phase_end: got {disp,sess,brk,run}=%h expected %h", act, want);
          end
        end
      end
    end
  end

  task automatic press(input logic s, input logic p, input logic c);
    btn_start  = s;
    btn_pause  = p;
    btn_cancel = c;
    @(negedge clk);
    btn_start  = 1'b0;
    btn_pause  = 1'b0;
    btn_cancel = 1'b0;
  endtask

  task automatic push_work_end();
    pd_exp_t e;
    sess_model = sess_model + 2'd1;
    e = {(sess_model == 2'd0) ? 16'h0200 : 16'h0100, sess_model, 1'b1, 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic push_break_end();
    pd_exp_t e;
    e = {16'h0100, sess_model, 1'b0, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic wait_phase_done(input int budget, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (phase_done !== 1'b1 && k < budget);
    n_cmp++;
    if (phase_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: phase_done not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; btn_cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({disp, running, paused, in_break, session_cnt, phase_done} !== {16'h0100, 6'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got disp=%h r=%b p=%b b=%b s=%0d pd=%b, expected 0100 and all zero",
               disp, running, paused, in_break, session_cnt, phase_done);
    end
  endtask

  task automatic test_ignored();
    press(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({running, paused, in_break} !== 3'b000 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL idle_pause_ignored: got flags=%b disp=%h expected 000 0100",
               {running, paused, in_break}, disp);
    end
    press(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({running, paused, in_break} !== 3'b000) begin
      n_bad++;
      $display("FAIL cancel_over_start: got flags=%b expected 000", {running, paused, in_break});
    end
  endtask

  task automatic test_start_latency();
    press(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({running, paused, in_break} !== 3'b100 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL start_running: got flags=%b disp=%h expected 100 0100",
               {running, paused, in_break}, disp);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL early_decrement: got disp=%h expected 0100 three cycles after start", disp);
    end
    @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0059) begin
      n_bad++;
      $display("FAIL first_decrement: got disp=%h expected 0059 four cycles after start", disp);
    end
    press(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({running, paused} !== 2'b10) begin
      n_bad++;
      $display("FAIL run_start_ignored: got running=%b paused=%b expected 1 0", running, paused);
    end
    // prescaler is now 1; two cycles later the next edge is a tick edge
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (paused !== 1'b1 || disp !== 16'h0059) begin
      n_bad++;
      $display("FAIL pause_beats_tick: got paused=%b disp=%h expected 1 0059", paused, disp);
    end
    press(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({running, paused, in_break} !== 3'b000 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL cancel_from_pause: got flags=%b disp=%h expected 000 0100",
               {running, paused, in_break}, disp);
    end
  endtask

  task automatic test_pause_resume();
    press(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);      // prescaler now 2
    press(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({running, paused} !== 2'b01 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL pause_enter: got running=%b paused=%b disp=%h expected 0 1 0100",
               running, paused, disp);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0100 || paused !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_hold: got disp=%h paused=%b expected 0100 1", disp, paused);
    end
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0100 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_early: got disp=%h running=%b expected 0100 1", disp, running);
    end
    @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0059) begin
      n_bad++;
      $display("FAIL resume_decrement: got disp=%h expected 0059 two cycles after resume", disp);
    end
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_work_phase();
    push_work_end();
    press(1'b1, 1'b0, 1'b0);
    repeat (239) @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0001) begin
      n_bad++;
      $display("FAIL countdown_0001: got disp=%h expected 0001", disp);
    end
    @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0000) begin
      n_bad++;
      $display("FAIL countdown_0000: got disp=%h expected 0000", disp);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0000 || phase_done !== 1'b0 || in_break !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_hold: got disp=%h pd=%b brk=%b expected 0000 0 0", disp, phase_done, in_break);
    end
    @(negedge clk);
    n_cmp++;
    if (phase_done !== 1'b1 || in_break !== 1'b1 || session_cnt !== 2'd1 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL work_expiry: got pd=%b brk=%b s=%0d disp=%h expected 1 1 1 0100",
               phase_done, in_break, session_cnt, disp);
    end
    @(negedge clk);
    n_cmp++;
    if (phase_done !== 1'b0 || in_break !== 1'b1) begin
      n_bad++;
      $display("FAIL pd_one_cycle: got pd=%b brk=%b expected 0 1", phase_done, in_break);
    end
    push_break_end();
    wait_phase_done(PHASE1 + 8, "break_expiry_wait");
  endtask

  task automatic test_long_break();
    for (int i = 0; i < 3; i++) begin
      push_work_end();
      press(1'b1, 1'b0, 1'b0);
      wait_phase_done(PHASE1 + 8, "work_wait");
      push_break_end();
      wait_phase_done(((sess_model == 2'd0) ? PHASE2 : PHASE1) + 8, "break_wait");
    end
    @(negedge clk);
    n_cmp++;
    if ({running, paused, in_break} !== 3'b000 || session_cnt !== 2'd0 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL after_long_break: got flags=%b s=%0d disp=%h expected 000 0 0100",
               {running, paused, in_break}, session_cnt, disp);
    end
  endtask

  task automatic test_cancel_in_break();
    push_work_end();
    press(1'b1, 1'b0, 1'b0);
    wait_phase_done(PHASE1 + 8, "work_wait_cancel");
    repeat (5) @(negedge clk);
    press(1'b0, 1'b1, 1'b1);
    sess_model = 2'd0;
    n_cmp++;
    if ({running, paused, in_break} !== 3'b000 || session_cnt !== 2'd0 || disp !== 16'h0100) begin
      n_bad++;
      $display("FAIL cancel_pause_break: got flags=%b s=%0d disp=%h expected 000 0 0100",
               {running, paused, in_break}, session_cnt, disp);
    end
  endtask

  task automatic test_reset_mid_phase();
    int k;
    press(1'b1, 1'b0, 1'b0);
    k = 0;
    while (disp !== 16'h0030 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (disp !== 16'h0030) begin
      n_bad++;
      $display("FAIL reach_0030: got disp=%h expected 0030 within 200 cycles", disp);
    end
    rst = 1'b1;
    btn_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    btn_start = 1'b0;
    n_cmp++;
    if ({disp, running, paused, in_break, session_cnt, phase_done} !== {16'h0100, 6'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_phase: got disp=%h r=%b p=%b b=%b s=%0d pd=%b, expected 0100 and all zero",
               disp, running, paused, in_break, session_cnt, phase_done);
    end
    press(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (disp !== 16'h0059) begin
      n_bad++;
      $display("FAIL restart_after_reset: got disp=%h expected 0059", disp);
    end
    press(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_start_latency();
    test_pause_resume();
    test_work_phase();
    test_long_break();
    test_cancel_in_break();
    test_reset_mid_phase();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d queued outcomes never seen, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pomo_seq_ctrl.md
POMO_SEQ_CTRL -- requirements
Module: pomo_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick; legal range >= 2.
REQ-002 Parameter WORK_MIN, default 25, meaning work-phase length in minutes; legal range 1..99.
REQ-003 Parameter BREAK_MIN, default 5, meaning short-break length in minutes; legal range 1..99.
REQ-004 Parameter LONG_MIN, default 15, meaning long-break length in minutes (after every 4th work phase); legal range 1..99.
REQ-005 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 btn_start  input  1  start/resume request, one-cycle pulse, debounced upstream.
REQ-008 btn_pause  input  1  pause/resume toggle request, one-cycle pulse.
REQ-009 btn_cancel  input  1  abort to idle, one-cycle pulse.
REQ-010 disp  output  16  BCD time {min_tens, min_ones, sec_tens, sec_ones}, drives the 7-seg driver x input.
REQ-011 running  output  1  high in RUN_WORK or RUN_BREAK.
REQ-012 paused  output  1  high in PAUSE_WORK or PAUSE_BREAK.
REQ-013 in_break  output  1  high in RUN_BREAK or PAUSE_BREAK.
REQ-014 session_cnt  output  2  completed work phases modulo 4.
REQ-015 phase_done  output  1  one-cycle pulse when a phase expires.

Function
REQ-016 All outputs SHALL be registered; an input pulse sampled at edge N SHALL be reflected on outputs after edge N.
REQ-017 States SHALL be IDLE, RUN_WORK, RUN_BREAK, PAUSE_WORK, PAUSE_BREAK.
REQ-018 Request priority when simultaneous SHALL be cancel > pause > start.
REQ-019 IDLE + btn_start -> RUN_WORK; disp loaded with WORK_MIN:00; prescaler cleared to 0.
REQ-020 RUN_x + btn_pause -> PAUSE_x; PAUSE_x + btn_pause or btn_start -> RUN_x; prescaler and disp held unchanged while paused.
REQ-021 Any non-IDLE state + btn_cancel -> IDLE; disp = WORK_MIN:00; session_cnt = 0; prescaler = 0; cancel in IDLE SHALL produce the same values.
REQ-022 btn_start in RUN_x, btn_pause in IDLE: ignored, no state change.
REQ-023 Prescaler SHALL count 0..TICK_DIV-1 only in RUN_x; a tick occurs on the cycle prescaler == TICK_DIV-1, then prescaler wraps to 0.
REQ-024 First decrement SHALL appear on disp exactly TICK_DIV cycles after running rises.
REQ-025 On tick with disp != 00:00: BCD decrement; sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; min_ones 0->9 with borrow into min_tens; each digit always 0..9 (sec_tens 0..5).
REQ-026 On tick with disp == 00:00 in RUN_WORK: -> RUN_BREAK; session_cnt += 1 (mod 4); disp = LONG_MIN:00 if the new session_cnt is 0, else BREAK_MIN:00; phase_done = 1 for that cycle.
REQ-027 On tick with disp == 00:00 in RUN_BREAK: -> IDLE; disp = WORK_MIN:00; session_cnt held; phase_done = 1 for that cycle.
REQ-028 00:00 SHALL therefore be displayed for one full tick period before the phase change.
REQ-029 btn_cancel or btn_pause coincident with a tick SHALL win; the tick is discarded.
REQ-030 Parameter-to-BCD conversion (tens = N/10, ones = N%10) SHALL be done at elaboration, no runtime divider.

Reset
REQ-031 On rst high at a clock edge: state IDLE, disp = WORK_MIN:00 in BCD, running 0, paused 0, in_break 0, session_cnt 0, phase_done 0, prescaler 0.
REQ-032 rst SHALL override all button inputs and may be asserted in any state, including mid-phase or during phase_done.

Verification (TICK_DIV=4, WORK_MIN=1, BREAK_MIN=1, LONG_MIN=2)
REQ-033 rst then idle -> disp 16'h0100, all flags 0; btn_start -> running 1 next cycle, disp 16'h0059 exactly 4 cycles later.
REQ-034 Run 61 ticks from start -> disp 16'h0000 for 4 cycles, then phase_done pulse, in_break 1, session_cnt 1, disp 16'h0100.
REQ-035 Four complete work phases -> 4th break loads disp 16'h0200, session_cnt 0; break expiry -> IDLE, disp 16'h0100.
REQ-036 btn_pause at prescaler=2, hold 20 cycles, btn_start -> disp unchanged while paused; next decrement 2 cycles after resume.
REQ-037 btn_cancel and btn_pause in same cycle while RUN_BREAK -> IDLE, disp 16'h0100, session_cnt 0, paused 0.
REQ-038 rst asserted at disp 16'h0030 in RUN_WORK -> next cycle all reset values per REQ-031.
